// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling off a shared oversample tick, optional parity,
// 1/2 stop bits, start-glitch rejection, per-word error flags and valid/ready with overrun.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 P_CLK,
  input  logic                 reset,
  input  logic                 i_RX,
  input  logic                 i_TICK,
  output logic [DATA_BITS-1:0] o_RX_DATA,
  output logic                 o_RX_VALID,
  input  logic                 i_RX_READY,
  output logic                 o_PARITY_ERR,
  output logic                 o_FRAME_ERR,
  output logic                 o_OVERRUN,
  output logic                 o_BUSY
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1   = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [TW-1:0]          tick_cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   data_sh;
  logic                   perr_r;
  logic                   ferr_acc;
  logic                   armed;
  logic                   rx_p0;
  logic                   rx_s;
  logic                   frame_done;
  logic                   ferr_final;
  logic                   accept;
  logic                   bit_point;

  function automatic logic parity_err(input logic [DATA_BITS-1:0] d, input logic p);
    return ((^d) ^ p) != 1'(PARITY_ODD);
  endfunction

  // Stage p0/s: two-flop synchroniser, preset high so reset never looks like a start bit
  always_ff @(posedge P_CLK or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= i_RX;
      rx_s  <= rx_p0;
    end
  end

  assign bit_point  = i_TICK && (tick_cnt == FULL_M1);
  assign frame_done = (state == STOP) && bit_point && (bit_cnt == LAST_STOP);
  assign ferr_final = ferr_acc | ~rx_s;
  assign accept     = o_RX_VALID & i_RX_READY;

  // Framing FSM; armed blocks a new start until the line has been seen high after a break
  always_ff @(posedge P_CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      data_sh  <= '0;
      perr_r   <= 1'b0;
      ferr_acc <= 1'b0;
      armed    <= 1'b1;
      o_BUSY   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (!rx_s && armed) begin
            state    <= START;
            tick_cnt <= '0;
            o_BUSY   <= 1'b1;
          end
        end
        START: begin
          if (i_TICK) begin
            if (tick_cnt == HALF_M1) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
                perr_r  <= 1'b0;
              end else begin
                state  <= IDLE;
                o_BUSY <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (bit_point) begin
            data_sh  <= {rx_s, data_sh[DATA_BITS-1:1]};
            tick_cnt <= '0;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt  <= '0;
              ferr_acc <= 1'b0;
              state    <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (i_TICK) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        PARITY: begin
          if (bit_point) begin
            perr_r   <= parity_err(data_sh, rx_s);
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= STOP;
          end else if (i_TICK) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (bit_point) begin
            tick_cnt <= '0;
            if (bit_cnt == LAST_STOP) begin
              state   <= IDLE;
              o_BUSY  <= 1'b0;
              armed   <= rx_s;
              bit_cnt <= '0;
            end else begin
              ferr_acc <= ferr_final;
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end else if (i_TICK) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          o_BUSY <= 1'b0;
        end
      endcase
    end
  end

  // Output holding register: a completion only loads when the slot is free or being freed
  always_ff @(posedge P_CLK or posedge reset) begin
    if (reset) begin
      o_RX_DATA    <= '0;
      o_RX_VALID   <= 1'b0;
      o_PARITY_ERR <= 1'b0;
      o_FRAME_ERR  <= 1'b0;
      o_OVERRUN    <= 1'b0;
    end else begin
      if (frame_done && (!o_RX_VALID || accept)) begin
        o_RX_DATA    <= data_sh;
        o_PARITY_ERR <= perr_r;
        o_FRAME_ERR  <= ferr_final;
        o_RX_VALID   <= 1'b1;
      end else if (accept) begin
        o_RX_VALID <= 1'b0;
      end
      if (frame_done && o_RX_VALID && !accept) o_OVERRUN <= 1'b1;
      else if (accept)                          o_OVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: five parameter variants share one serial line,
// a table of frames plus hand sequences for glitch, overrun, mid-frame reset and break.
module tb_uart_rx_param;

  localparam int BITCLK = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic ready = 1'b0;
  logic tick;
  logic [1:0] tdiv = 2'd0;

  logic [7:0] d0, d1, d2;
  logic [4:0] d3;
  logic [8:0] d4;
  logic [4:0] valid, perr, ferr, ovr, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign tick = (tdiv == 2'd3);

  uart_rx_param #(.DATA_BITS(8)) u0 (
    .P_CLK(clk), .reset(reset), .i_RX(rx), .i_TICK(tick), .o_RX_DATA(d0), .o_RX_VALID(valid[0]),
    .i_RX_READY(ready), .o_PARITY_ERR(perr[0]), .o_FRAME_ERR(ferr[0]), .o_OVERRUN(ovr[0]), .o_BUSY(busy[0]));
  uart_rx_param #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .P_CLK(clk), .reset(reset), .i_RX(rx), .i_TICK(tick), .o_RX_DATA(d1), .o_RX_VALID(valid[1]),
    .i_RX_READY(ready), .o_PARITY_ERR(perr[1]), .o_FRAME_ERR(ferr[1]), .o_OVERRUN(ovr[1]), .o_BUSY(busy[1]));
  uart_rx_param #(.DATA_BITS(8), .STOP_BITS(2)) u2 (
    .P_CLK(clk), .reset(reset), .i_RX(rx), .i_TICK(tick), .o_RX_DATA(d2), .o_RX_VALID(valid[2]),
    .i_RX_READY(ready), .o_PARITY_ERR(perr[2]), .o_FRAME_ERR(ferr[2]), .o_OVERRUN(ovr[2]), .o_BUSY(busy[2]));
  uart_rx_param #(.DATA_BITS(5)) u3 (
    .P_CLK(clk), .reset(reset), .i_RX(rx), .i_TICK(tick), .o_RX_DATA(d3), .o_RX_VALID(valid[3]),
    .i_RX_READY(ready), .o_PARITY_ERR(perr[3]), .o_FRAME_ERR(ferr[3]), .o_OVERRUN(ovr[3]), .o_BUSY(busy[3]));
  uart_rx_param #(.DATA_BITS(9)) u4 (
    .P_CLK(clk), .reset(reset), .i_RX(rx), .i_TICK(tick), .o_RX_DATA(d4), .o_RX_VALID(valid[4]),
    .i_RX_READY(ready), .o_PARITY_ERR(perr[4]), .o_FRAME_ERR(ferr[4]), .o_OVERRUN(ovr[4]), .o_BUSY(busy[4]));

  function automatic logic [8:0] dsel(input int k);
    case (k)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      2:       return {1'b0, d2};
      3:       return {4'b0, d3};
      default: return d4;
    endcase
  endfunction

  typedef struct {
    int         inst;
    logic [8:0] d;
    int         nbits;
    bit         pe;
    bit         pv;
    bit         s1;
    int         ns;
    bit         s2;
    logic [8:0] ed;
    bit         ep;
    bit         ef;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clk(BITCLK);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nbits, input bit pe, input bit pv,
                            input bit s1, input int ns, input bit s2);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (pe) send_bit(pv);
    send_bit(s1);
    if (ns == 2) send_bit(s2);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    wait_clk(n);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    rx = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(2);
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    wait_clk(1);
    ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[1]  = '{0, 9'h000, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1, 9'h000, 1'b0, 1'b0};
    vecs[2]  = '{0, 9'h081, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 9'h081, 1'b0, 1'b1};
    vecs[3]  = '{1, 9'h03C, 8, 1'b1, 1'b0, 1'b1, 1, 1'b1, 9'h03C, 1'b0, 1'b0};
    vecs[4]  = '{1, 9'h03C, 8, 1'b1, 1'b1, 1'b1, 1, 1'b1, 9'h03C, 1'b1, 1'b0};
    vecs[5]  = '{1, 9'h007, 8, 1'b1, 1'b1, 1'b1, 1, 1'b1, 9'h007, 1'b0, 1'b0};
    vecs[6]  = '{2, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 2, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[7]  = '{2, 9'h081, 8, 1'b0, 1'b0, 1'b1, 2, 1'b0, 9'h081, 1'b0, 1'b1};
    vecs[8]  = '{3, 9'h01F, 5, 1'b0, 1'b0, 1'b1, 1, 1'b1, 9'h01F, 1'b0, 1'b0};
    vecs[9]  = '{3, 9'h00A, 5, 1'b0, 1'b0, 1'b1, 1, 1'b1, 9'h00A, 1'b0, 1'b0};
    vecs[10] = '{4, 9'h1AB, 9, 1'b0, 1'b0, 1'b1, 1, 1'b1, 9'h1AB, 1'b0, 1'b0};
    vecs[11] = '{4, 9'h155, 9, 1'b0, 1'b0, 1'b1, 1, 1'b1, 9'h155, 1'b0, 1'b0};

    wait_clk(3);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_data", 32'(dsel(4)), 32'h0);
    check("reset_perr", 32'(perr), 32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
    check("reset_ovr", 32'(ovr), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    idle(32);

    for (int v = 0; v < 12; v++) begin
      pulse_reset();
      idle(32);
      send_frame(vecs[v].d, vecs[v].nbits, vecs[v].pe, vecs[v].pv, vecs[v].s1, vecs[v].ns, vecs[v].s2);
      check($sformatf("vec%0d_valid", v), 32'(valid[vecs[v].inst]), 32'h1);
      check($sformatf("vec%0d_data", v), 32'(dsel(vecs[v].inst)), 32'(vecs[v].ed));
      check($sformatf("vec%0d_perr", v), 32'(perr[vecs[v].inst]), 32'(vecs[v].ep));
      check($sformatf("vec%0d_ferr", v), 32'(ferr[vecs[v].inst]), 32'(vecs[v].ef));
      check($sformatf("vec%0d_ovr", v), 32'(ovr[vecs[v].inst]), 32'h0);
      pulse_ready();
      check($sformatf("vec%0d_valid_clr", v), 32'(valid[vecs[v].inst]), 32'h0);
    end

    // start glitch: 4 ticks low then high
    pulse_reset();
    idle(32);
    rx = 1'b0;
    wait_clk(16);
    check("glitch_busy_start", 32'(busy[0]), 32'h1);
    idle(64);
    check("glitch_busy_idle", 32'(busy[0]), 32'h0);
    check("glitch_no_valid", 32'(valid[0]), 32'h0);
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    check("glitch_next_valid", 32'(valid[0]), 32'h1);
    check("glitch_next_data", 32'(dsel(0)), 32'h3C);
    check("glitch_next_ferr", 32'(ferr[0]), 32'h0);

    // overrun: two frames with READY low
    pulse_reset();
    idle(32);
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    check("ovr_valid", 32'(valid[0]), 32'h1);
    check("ovr_data_held", 32'(dsel(0)), 32'h11);
    check("ovr_flag", 32'(ovr[0]), 32'h1);
    pulse_ready();
    check("ovr_valid_clr", 32'(valid[0]), 32'h0);
    check("ovr_flag_clr", 32'(ovr[0]), 32'h0);

    // reset in the middle of data bit 3
    pulse_reset();
    idle(32);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    wait_clk(32);
    check("midrst_busy_before", 32'(busy[0]), 32'h1);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy[0]), 32'h0);
    check("midrst_valid", 32'(valid[0]), 32'h0);
    wait_clk(2);
    reset = 1'b0;
    idle(BITCLK * 2);
    check("midrst_no_valid", 32'(valid[0]), 32'h0);
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    check("midrst_next_valid", 32'(valid[0]), 32'h1);
    check("midrst_next_data", 32'(dsel(0)), 32'h5A);
    check("midrst_next_ferr", 32'(ferr[0]), 32'h0);

    // break: line held low well past the frame
    pulse_reset();
    idle(32);
    send_frame(9'h000, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    wait_clk(BITCLK * 3);
    check("break_valid", 32'(valid[0]), 32'h1);
    check("break_data", 32'(dsel(0)), 32'h0);
    check("break_ferr", 32'(ferr[0]), 32'h1);
    check("break_busy", 32'(busy[0]), 32'h0);
    idle(BITCLK);
    pulse_ready();
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    check("break_next_valid", 32'(valid[0]), 32'h1);
    check("break_next_data", 32'(dsel(0)), 32'hA5);
    check("break_next_ferr", 32'(ferr[0]), 32'h0);
    check("break_next_ovr", 32'(ovr[0]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
